// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared state encoding and default frame/timeout constants
package canny_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_IMG_WIDTH     = 512;
    localparam int DEF_IMG_HEIGHT    = 512;
    localparam int DEF_DRAIN_TIMEOUT = 4096;

endpackage

// File: rtl/canny_timeout_counter.sv
// rtl/canny_timeout_counter.sv - idle-cycle counter that flags expiry after LIMIT cycles
module canny_timeout_counter
    import canny_pkg::*;
#(
    parameter int LIMIT = DEF_DRAIN_TIMEOUT
) (
    input  logic clk,
    input  logic rstN,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int TW = $clog2(LIMIT + 1);
    localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_count <= '0;
        end else if (clear || !enable) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + TW'(1);
        end
    end

    // Fires on the LIMIT-th consecutive idle cycle so the owner can act on that same edge.
    assign expired = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/canny_frame_controller.sv
// rtl/canny_frame_controller.sv - frame sequencer feeding the Canny pipeline and tracking NMS drain
module canny_frame_controller
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH     = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT    = DEF_IMG_HEIGHT,
    parameter int EXP_OUT       = (IMG_WIDTH - 6) * (IMG_HEIGHT - 6),
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    localparam int CW           = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    src_pixel,
    input  logic          src_valid,
    output logic          src_ready,
    output logic [7:0]    pixel_in,
    output logic          pixel_in_valid,
    input  logic          nms_valid,
    output logic          busy,
    output logic          frame_done,
    output logic          timeout_err,
    output logic [CW-1:0] in_count,
    output logic [CW-1:0] out_count
);

    localparam logic [CW-1:0] LAST_PX = CW'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [CW-1:0] EXP_CNT = CW'(EXP_OUT);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_pixel_in;
    logic          r_pixel_in_valid;
    logic          r_timeout_err;
    logic [CW-1:0] r_in_count;
    logic [CW-1:0] r_out_count;

    logic w_src_ready;
    logic w_transfer;
    logic w_last_px;
    logic w_count_nms;
    logic w_start_frame;
    logic w_set_err;
    logic w_drain;
    logic w_to_clear;
    logic w_to_expired;

    // Abort suppresses ready in its own cycle so no pixel slips in behind it.
    assign w_src_ready = (r_state == ST_STREAM) && !abort;
    assign w_transfer  = src_valid && w_src_ready;
    assign w_last_px   = w_transfer && (r_in_count == LAST_PX);
    assign w_count_nms = nms_valid && (r_out_count != EXP_CNT)
                         && ((r_state == ST_STREAM) || (r_state == ST_DRAIN));
    assign w_drain     = (r_state == ST_DRAIN);
    assign w_to_clear  = nms_valid || !w_drain;

    canny_timeout_counter #(
        .LIMIT (DRAIN_TIMEOUT)
    ) u_drain_timeout (
        .clk     (clk),
        .rstN    (rstN),
        .enable  (w_drain),
        .clear   (w_to_clear),
        .expired (w_to_expired)
    );

    always_comb begin
        w_next        = r_state;
        w_start_frame = 1'b0;
        w_set_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next        = ST_STREAM;
                    w_start_frame = 1'b1;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_last_px) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (r_out_count == EXP_CNT) begin
                    w_next = ST_DONE;
                end else if (w_to_expired) begin
                    w_next    = ST_IDLE;
                    w_set_err = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pixel_in       <= 8'd0;
            r_pixel_in_valid <= 1'b0;
        end else begin
            r_pixel_in_valid <= w_transfer;
            if (w_transfer) begin
                r_pixel_in <= src_pixel;
            end
        end
    end

    // Counts survive abort and timeout; only a fresh start clears them.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_in_count    <= '0;
            r_out_count   <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_start_frame) begin
            r_in_count    <= '0;
            r_out_count   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_in_count <= r_in_count + CW'(1);
            end
            if (w_count_nms) begin
                r_out_count <= r_out_count + CW'(1);
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign src_ready      = w_src_ready;
    assign pixel_in       = r_pixel_in;
    assign pixel_in_valid = r_pixel_in_valid;
    assign busy           = (r_state != ST_IDLE);
    assign frame_done     = (r_state == ST_DONE) && !abort;
    assign timeout_err    = r_timeout_err;
    assign in_count       = r_in_count;
    assign out_count      = r_out_count;

endmodule

// File: tb/tb_canny_frame_controller.sv
// tb/tb_canny_frame_controller.sv - directed bench for canny_frame_controller on an 8x8 frame
module tb_canny_frame_controller;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int NPX = W * H;
    localparam int CW  = $clog2(W * H + 1);

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic          abort;
    logic [7:0]    src_pixel;
    logic          src_valid;
    logic          src_ready;
    logic [7:0]    pixel_in;
    logic          pixel_in_valid;
    logic          nms_valid;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;

    canny_frame_controller #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .EXP_OUT       (4),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .start          (start),
        .abort          (abort),
        .src_pixel      (src_pixel),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .nms_valid      (nms_valid),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err),
        .in_count       (in_count),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [7:0] last_pix = 8'd0;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
    end

    typedef struct {
        int toggle;
        int nms_stream;
        int nms_drain;
        int abort_at;
        int exp_in;
        int exp_out;
        int exp_done;
        int exp_terr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic push(input int n);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = 8'(i * 13 + 1);
            src_valid = 1'b1;
            src_pixel = p;
            cyc();
            last_pix = p;
        end
        src_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int sent;
        int c;
        int base;
        logic xfer;
        logic [7:0] pix;
        base = done_cnt;
        start_frame();
        chk("busy_after_start", busy, 1);
        chk("in_count_cleared", in_count, 0);
        chk("terr_cleared", timeout_err, 0);
        sent = 0;
        c = 0;
        while (sent < NPX && !(v.abort_at >= 0 && sent == v.abort_at) && c < 300) begin
            xfer      = (v.toggle == 0) || (c % 2 == 0);
            pix       = 8'(sent * 37 + idx * 11 + 5);
            src_valid = xfer;
            src_pixel = xfer ? pix : 8'hEE;
            nms_valid = (c < v.nms_stream);
            #1;
            chk("src_ready_stream", src_ready, 1);
            cyc();
            chk("pix_valid_latency", pixel_in_valid, xfer);
            if (xfer) begin
                last_pix = pix;
                sent++;
            end
            chk("pix_data", pixel_in, last_pix);
            c++;
        end
        src_valid = 1'b0;
        nms_valid = 1'b0;
        if (c >= 300) begin
            total++;
            bad++;
            $display("FAIL stream_budget: sent %0d of %0d", sent, NPX);
        end
        if (v.abort_at >= 0) begin
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_src_ready", src_ready, 0);
            chk("abort_pix_valid", pixel_in_valid, 0);
            repeat (3) cyc();
        end else begin
            #1;
            chk("src_ready_drain", src_ready, 0);
            for (int i = 0; i < v.nms_drain; i++) begin
                nms_valid = 1'b1;
                cyc();
                nms_valid = 1'b0;
                cyc();
            end
            repeat (40) cyc();
        end
        chk("in_count", in_count, v.exp_in);
        chk("out_count", out_count, v.exp_out);
        chk("frame_done_pulses", done_cnt - base, v.exp_done);
        chk("timeout_err", timeout_err, v.exp_terr);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        int k;
        int base;
        rstN      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        src_valid = 1'b0;
        src_pixel = 8'd0;
        nms_valid = 1'b0;

        vecs[0] = '{0, 0, 4, -1, 64, 4, 1, 0};
        vecs[1] = '{1, 0, 4, -1, 64, 4, 1, 0};
        vecs[2] = '{0, 6, 0, -1, 64, 4, 1, 0};
        vecs[3] = '{1, 0, 0, 30, 30, 0, 0, 0};
        vecs[4] = '{0, 2, 2, -1, 64, 4, 1, 0};
        vecs[5] = '{0, 0, 2, -1, 64, 2, 0, 1};

        repeat (3) cyc();
        chk("rst_src_ready", src_ready, 0);
        chk("rst_pix_valid", pixel_in_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_pixel_in", pixel_in, 0);
        chk("rst_in_count", in_count, 0);
        chk("rst_out_count", out_count, 0);
        rstN = 1'b1;
        cyc();

        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        cyc();
        chk("start_abort_idle2", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        nms_valid = 1'b1;
        repeat (3) cyc();
        nms_valid = 1'b0;
        chk("nms_idle_ignored", out_count, 2);

        start_frame();
        chk("restart_clears_terr", timeout_err, 0);
        push(NPX);
        nms_valid = 1'b1;
        cyc();
        nms_valid = 1'b0;
        k = 0;
        base = done_cnt;
        while (!timeout_err && k < 40) begin
            cyc();
            k++;
        end
        chk("timeout_latency", k, 16);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_done", done_cnt - base, 0);

        start_frame();
        push(NPX);
        for (int i = 0; i < 3; i++) begin
            nms_valid = 1'b1;
            cyc();
            nms_valid = 1'b0;
            cyc();
        end
        nms_valid = 1'b1;
        cyc();
        nms_valid = 1'b0;
        chk("done_not_early", frame_done, 0);
        cyc();
        chk("done_pulse", frame_done, 1);
        chk("done_busy", busy, 1);
        cyc();
        chk("done_one_cycle", frame_done, 0);
        chk("done_busy_after", busy, 0);

        start_frame();
        push(20);
        start     = 1'b1;
        src_valid = 1'b1;
        src_pixel = 8'h5A;
        cyc();
        last_pix  = 8'h5A;
        start     = 1'b0;
        src_valid = 1'b0;
        push(19);
        chk("start_in_stream_ignored", in_count, 40);
        chk("pre_reset_busy", busy, 1);
        #2;
        rstN = 1'b0;
        #1;
        chk("async_rst_src_ready", src_ready, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_pixel_in", pixel_in, 0);
        chk("async_rst_in_count", in_count, 0);
        chk("async_rst_out_count", out_count, 0);
        chk("async_rst_frame_done", frame_done, 0);
        cyc();
        rstN      = 1'b1;
        src_valid = 1'b1;
        src_pixel = 8'h33;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("post_rst_no_valid", pixel_in_valid, 0);
        end
        src_valid = 1'b0;
        chk("post_rst_in_count", in_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
